div_remainder_unit: RTL and testbench
=====================================

# div_remainder_unit

Iterative restoring-division datapath and sequencer for the multicycle divider. It sits directly downstream of the Divisor register and consumes its 32-bit output each cycle. It holds the 64-bit Remainder/Quotient shift register, performs one shift/subtract/restore step per clock, and signals completion to the top level with a Start/Ready handshake. Unsigned operands only.

## Interface
- WIDTH, 32, operand width. Only 32 is supported, and all widths below assume it.

Ports:
- Clk  input  1  single clock. Rising-edge triggered.
- Reset  input  1  asynchronous, active-low reset (Reset = 0 resets the block).
- Start  input  1  request a new division. Sampled on the rising edge of Clk.
- Dividend_in  input  32  dividend. Captured on the edge that accepts Start.
- Divisor_in  input  32  connected to the Divisor register's Divisor_out. Not latched internally; it must be stable from the accepting edge until Ready.
- Quotient  output  32  lower half of the internal register, Rem[31:0].
- Remainder  output  32  upper half of the internal register, Rem[63:32].
- Busy  output  1  high while in CALC.
- Ready  output  1  high while in DONE; results are valid.
- Div_by_zero  output  1  high in DONE when the operation had Divisor_in == 0.

## Operation
- Internal state:
  - 64-bit Rem register.
  - 5-bit iteration counter Cnt.
  - Div_by_zero flag.
  - State register with states IDLE, CALC, DONE.
- Reset (Reset = 0, asynchronous): State = IDLE, Rem = 0, Cnt = 0, Div_by_zero = 0. All outputs go to 0 immediately, without waiting for a clock edge.
- IDLE or DONE with Start = 1, on the rising edge:
  - If Divisor_in != 0: Rem = {32'h0, Dividend_in}, Cnt = 0, Div_by_zero = 0, go to CALC.
  - If Divisor_in == 0: Rem = {Dividend_in, 32'hFFFF_FFFF}, Div_by_zero = 1, go to DONE. This yields Quotient = all ones and Remainder = dividend.
- IDLE with Start = 0: hold.
- DONE with Start = 0: hold. Outputs stay valid indefinitely.
- CALC, one iteration per edge:
  - c = Rem[63].
  - s = {Rem[62:32], Rem[31]} (32 bits).
  - d = {c, s} - {1'b0, Divisor_in}, computed at 33 bits.
  - If d[32] == 0: Rem = {d[31:0], Rem[30:0], 1'b1}.
  - Else (restore): Rem = {s, Rem[30:0], 1'b0}.
  - Cnt increments by 1.
  - If Cnt == 31 at this edge, go to DONE; otherwise stay in CALC.
- Start during CALC is ignored. Dividend_in is not sampled and the current operation is not disturbed.
- Reset asserted mid-CALC aborts the operation immediately. After Reset is released the block is in IDLE and needs a new Start.
- The 33-bit compare is mandatory. Without it, divisors ≥ 2^31 produce wrong quotients.

## Timing
- Busy and Ready are decoded from the state register, so they are glitch-free and change only on Clk edges or on Reset.
- Normal latency:
  - Edge E0 accepts Start; Busy = 1 after E0.
  - Edges E1..E32 perform iterations 0..31.
  - After E32: Busy = 0, Ready = 1. That is 32 edges after E0, or 33 edges counting E0.
- Divide-by-zero latency: Ready = 1 after E0 itself. Busy never asserts.
- Back-to-back operations: Start held high in DONE launches the next operation on the following edge. Ready falls and Busy rises on that same edge.
- Quotient and Remainder show intermediate values during CALC and are meaningful only while Ready = 1.

## Test plan
- Reset = 0 with random Start/Dividend_in/Divisor_in → all outputs 0 with no clock edge required. Release reset, hold Start = 0 for 5 cycles → stays IDLE, outputs unchanged.
- Dividend 100, Divisor 7, Start for 1 cycle → Busy high for 32 cycles, then Ready = 1 exactly 32 edges after acceptance with Quotient = 14, Remainder = 2.
- Wide divisor cases:
  - 32'hFFFF_FFFF / 32'h8000_0001 → Q = 1, R = 32'h7FFF_FFFE.
  - 32'hFFFF_FFFF / 1 → Q = 32'hFFFF_FFFF, R = 0.
- 5 / 9 → Q = 0, R = 5. Dividend 32'h1234_5678 with Divisor 0 → Ready one edge after Start, Div_by_zero = 1, Q = 32'hFFFF_FFFF, R = 32'h1234_5678.
- Start 100/7, then pulse Start with Dividend_in = 50 at iteration 10 → ignored; result still Q = 14, R = 2 at the same cycle. Keep Start high in DONE with 9/3 → next result Q = 3, R = 0 after another 32 edges.
- Start 100/7, assert Reset = 0 at iteration 20 → outputs clear immediately, State = IDLE. After release, 81/9 → Q = 9, R = 0 with normal latency.

Source files
------------

// File: rtl/div_remainder_unit.sv
// div_remainder_unit
// Iterative restoring divider: one shift/subtract/restore step per clock on a
// 64-bit Remainder/Quotient register, with a Start/Ready handshake.
// Unsigned operands only; WIDTH must be 32.
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous active-low reset
//   Start        in   request a new division (accepted in IDLE or DONE)
//   Dividend_in  in   [31:0] dividend, captured on the accepting edge
//   Divisor_in   in   [31:0] divisor, not latched; held stable until Ready
//   Quotient     out  [31:0] Rem[31:0]
//   Remainder    out  [31:0] Rem[63:32]
//   Busy         out  high while iterating
//   Ready        out  high while results are valid
//   Div_by_zero  out  high with Ready when the divisor was zero
module div_remainder_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend_in,
  input  logic [WIDTH-1:0] Divisor_in,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Ready,
  output logic             Div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2*WIDTH-1:0] r_rem;
  logic [4:0]         r_cnt;
  logic               r_dbz;

  logic               w_accept;
  logic               w_div_zero;
  logic               w_last;
  logic               w_c;
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH:0]     w_d;

  assign w_div_zero = (Divisor_in == '0);
  assign w_accept   = Start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_cnt == 5'(WIDTH - 1));

  // The bit shifted out of the top of the remainder joins the trial
  // subtraction as a 33rd bit; without it divisors >= 2^31 go wrong.
  assign w_c = r_rem[2*WIDTH-1];
  assign w_s = {r_rem[2*WIDTH-2:WIDTH], r_rem[WIDTH-1]};
  assign w_d = {w_c, w_s} - {1'b0, Divisor_in};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (Start) begin
          w_state_next = w_div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rem <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_div_zero) begin
        // Quotient reads all ones, remainder reads the dividend.
        r_rem <= {Dividend_in, {WIDTH{1'b1}}};
        r_dbz <= 1'b1;
      end else begin
        r_rem <= {{WIDTH{1'b0}}, Dividend_in};
        r_dbz <= 1'b0;
      end
    end else if (r_state == CALC) begin
      if (!w_d[WIDTH]) begin
        r_rem <= {w_d[WIDTH-1:0], r_rem[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= {w_s, r_rem[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign Quotient    = r_rem[WIDTH-1:0];
  assign Remainder   = r_rem[2*WIDTH-1:WIDTH];
  assign Busy        = (r_state == CALC);
  assign Ready       = (r_state == DONE);
  assign Div_by_zero = r_dbz && (r_state == DONE);

endmodule

// File: tb/tb_div_remainder_unit.sv
module tb_div_remainder_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [31:0] Dividend_in;
  logic [31:0] Divisor_in;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        Busy;
  logic        Ready;
  logic        Div_by_zero;

  int checks;
  int failures;

  div_remainder_unit #(.WIDTH(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Dividend_in(Dividend_in),
    .Divisor_in (Divisor_in),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .Busy       (Busy),
    .Ready      (Ready),
    .Div_by_zero(Div_by_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".q"},    64'(Quotient),    64'h0);
    check({name, ".r"},    64'(Remainder),   64'h0);
    check({name, ".busy"}, 64'(Busy),        64'h0);
    check({name, ".rdy"},  64'(Ready),       64'h0);
    check({name, ".dbz"},  64'(Div_by_zero), 64'h0);
  endtask

  // Called at a negedge; counts edges until Ready, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!Ready && n < 40) begin
      @(posedge Clk);
      @(negedge Clk);
      n++;
    end
  endtask

  // Called at a negedge; accepts on the next posedge (E0), returns at the negedge after E0.
  task automatic launch(input logic [31:0] dvd, input logic [31:0] dvs);
    Start       = 1'b1;
    Dividend_in = dvd;
    Divisor_in  = dvs;
    @(posedge Clk);
    @(negedge Clk);
    Start       = 1'b0;
    Dividend_in = $urandom;
  endtask

  task automatic run_vec(input int idx);
    int n;
    launch(vecs[idx].dividend, vecs[idx].divisor);
    if (vecs[idx].exp_lat == 0) begin
      check($sformatf("v%0d.busy_e0", idx), 64'(Busy), 64'h0);
    end else begin
      check($sformatf("v%0d.busy_e0", idx), 64'(Busy), 64'h1);
    end
    wait_ready(n);
    check($sformatf("v%0d.latency", idx), 64'(n), 64'(vecs[idx].exp_lat));
    check($sformatf("v%0d.q", idx),       64'(Quotient),    64'(vecs[idx].exp_q));
    check($sformatf("v%0d.r", idx),       64'(Remainder),   64'(vecs[idx].exp_r));
    check($sformatf("v%0d.dbz", idx),     64'(Div_by_zero), 64'(vecs[idx].exp_dbz));
    check($sformatf("v%0d.busy_end", idx), 64'(Busy),       64'h0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 32};
    vecs[1] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0, 32};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 32};
    vecs[3] = '{32'd5,         32'd9,         32'd0,         32'd5,         1'b0, 32};
    vecs[4] = '{32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 32};
    vecs[6] = '{32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF,         1'b0, 32};
    vecs[7] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 32};
    vecs[8] = '{32'd1000,      32'd10,        32'd100,       32'd0,         1'b0, 32};

    // Asynchronous reset: asserted between clock edges, checked before the next edge.
    Reset       = 1'b1;
    Start       = 1'b0;
    Dividend_in = '0;
    Divisor_in  = '0;
    #2;
    Reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Start       = 1'($urandom);
      Dividend_in = $urandom;
      Divisor_in  = $urandom;
    end
    @(negedge Clk);
    check_all_zero("rst_held");
    Start = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
    end
    check_all_zero("idle_hold");

    for (int i = 0; i < 9; i++) begin
      run_vec(i);
    end

    // Start pulsed mid-operation is ignored.
    launch(32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    Start       = 1'b1;
    Dividend_in = 32'd50;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    check("ign.busy", 64'(Busy), 64'h1);
    wait_ready(n);
    check("ign.latency", 64'(n + 11), 64'd32);
    check("ign.q", 64'(Quotient),  64'd14);
    check("ign.r", 64'(Remainder), 64'd2);

    // Start held in DONE launches the next operation on the following edge.
    launch(32'd9, 32'd3);
    check("b2b.rdy_drop", 64'(Ready), 64'h0);
    check("b2b.busy",     64'(Busy),  64'h1);
    wait_ready(n);
    check("b2b.latency", 64'(n), 64'd32);
    check("b2b.q", 64'(Quotient),  64'd3);
    check("b2b.r", 64'(Remainder), 64'd0);

    // Reset mid-operation aborts immediately.
    launch(32'd100, 32'd7);
    for (int i = 0; i < 19; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    check("abort.busy_pre", 64'(Busy), 64'h1);
    Reset = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check_all_zero("abort_idle");
    launch(32'd81, 32'd9);
    wait_ready(n);
    check("post.latency", 64'(n), 64'd32);
    check("post.q", 64'(Quotient),  64'd9);
    check("post.r", 64'(Remainder), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
